// File: rtl/timer_counter_pkg.sv
// Shared constants and types for the down-counting interrupt timer.
// Register map, CTRL bit layout, mode and FSM encodings.
package timer_counter_pkg;

    localparam int CTRL_W = 4;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    // Modes 1x fold onto one-shot.
    function automatic logic [1:0] eff_mode(input logic [CTRL_W-1:0] c);
        logic [1:0] m;
        m = c[CTRL_MODE_HI:CTRL_MODE_LO];
        return (m == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Peripheral-bridge port bundle for the timer.
// Bridge drives addr/WE/WD; timer returns RD and IRQ.
interface timer_counter_if;

    logic [1:0]  addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    modport master (
        output addr,
        output WE,
        output WD,
        input  RD,
        input  IRQ
    );

    modport slave (
        input  addr,
        input  WE,
        input  WD,
        output RD,
        output IRQ
    );

endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// IRQ feeds one HWInt bit; CTRL writes acknowledge the interrupt.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [COUNT_W-1:0]  preset_q, preset_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                irq_q, irq_d;

    logic                en;
    logic                fire;
    logic [31:0]         preset_ext;
    logic [31:0]         count_ext;
    logic [31:0]         rd_mux;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;
        fire     = 1'b0;
        en       = ctrl_q[CTRL_EN];

        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = en ? S_CNT : S_IDLE;
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q > COUNT_W'(1)) begin
                    count_d = count_q - COUNT_W'(1);
                end else begin
                    // Terminal case also covers PRESET=0.
                    count_d = '0;
                    fire    = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                unique case (eff_mode(ctrl_q))
                    MODE_RELOAD:  irq_d = 1'b0;
                    MODE_ONESHOT: ctrl_d[CTRL_EN] = 1'b0;
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.WE) begin
            unique case (1'b1)
                (bus.addr == REG_CTRL): begin
                    ctrl_d = bus.WD[CTRL_W-1:0];
                    irq_d  = 1'b0;
                end
                (bus.addr == REG_PRESET): begin
                    preset_d = bus.WD[COUNT_W-1:0];
                end
                default: ;
            endcase
        end

        // Terminal count beats a same-cycle acknowledge.
        if (fire) irq_d = 1'b1;
    end

    always_comb begin
        preset_ext = '0;
        count_ext  = '0;
        preset_ext[COUNT_W-1:0] = preset_q;
        count_ext[COUNT_W-1:0]  = count_q;
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (bus.addr == REG_CTRL):   rd_mux = {{(32-CTRL_W){1'b0}}, ctrl_q};
            (bus.addr == REG_PRESET): rd_mux = preset_ext;
            (bus.addr == REG_COUNT):  rd_mux = count_ext;
            default:                  rd_mux = '0;
        endcase
    end

    assign bus.RD  = rd_mux;
    assign bus.IRQ = irq_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with a cycle-level reference model.
// Every negedge compares IRQ and RD against the model.
`timescale 1ns/1ps
module tb_timer_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    timer_counter_if bus();

    timer_counter #(.COUNT_W(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: timeline of a programmable countdown.
    logic [3:0]  m_ctrl = '0;
    logic [31:0] m_pre  = '0;
    logic [31:0] m_cnt  = '0;
    bit          m_irq  = 1'b0;
    int          m_ph   = 0; // 0 waiting, 1 reload due, 2 counting, 3 fired

    always @(posedge clk or negedge rst_n) begin
        logic [3:0]  c;
        logic [31:0] p;
        logic [31:0] n;
        bit          q;
        bit          fired;
        int          ph;
        if (!rst_n) begin
            m_ctrl = '0; m_pre = '0; m_cnt = '0; m_irq = 0; m_ph = 0;
        end else begin
            c = m_ctrl; p = m_pre; n = m_cnt; q = m_irq;
            ph = m_ph; fired = 0;
            if (m_ph == 0) begin
                if (m_ctrl[0]) ph = 1;
            end else if (m_ph == 1) begin
                n  = m_pre;
                ph = m_ctrl[0] ? 2 : 0;
            end else if (m_ph == 2) begin
                if (!m_ctrl[0]) ph = 0;
                else if (m_cnt >= 2) n = m_cnt - 1;
                else begin n = 0; fired = 1; ph = 3; end
            end else begin
                ph = 0;
                if (m_ctrl[2:1] == 2'b01) q = 0;
                else c[0] = 1'b0;
            end
            if (bus.WE && bus.addr == 2'd0) begin c = bus.WD[3:0]; q = 0; end
            if (bus.WE && bus.addr == 2'd1) p = bus.WD;
            if (fired) q = 1;
            m_ctrl = c; m_pre = p; m_cnt = n; m_irq = q; m_ph = ph;
        end
    end

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        if (a == 2'd0) return {28'd0, m_ctrl};
        if (a == 2'd1) return m_pre;
        if (a == 2'd2) return m_cnt;
        return 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_irq", {31'd0, bus.IRQ}, {31'd0, m_irq & m_ctrl[3]});
        chk("model_rd", bus.RD, m_rd(bus.addr));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a; bus.WD = d; bus.WE = 1'b1;
        @(posedge clk);
        #2;
        bus.WE = 1'b0; bus.addr = 2'd2;
    endtask

    task automatic rd_at(input string nm, input logic [1:0] a,
                         input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(nm, bus.RD, exp);
        bus.addr = 2'd2;
    endtask

    initial begin
        bus.addr = 2'd0; bus.WE = 1'b0; bus.WD = '0;
        #1 rst_n = 1'b0;
        #1;
        rd_at("rst_ctrl", 2'd0, 32'd0);
        rd_at("rst_pre", 2'd1, 32'd0);
        rd_at("rst_cnt", 2'd2, 32'd0);
        chk("rst_irq", {31'd0, bus.IRQ}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // One-shot, PRESET=5: IRQ at t0+7, held until CTRL write
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step(6);
        chk("os_pre", {31'd0, bus.IRQ}, 32'd0);
        step(1);
        chk("os_irq", {31'd0, bus.IRQ}, 32'd1);
        step(1);
        rd_at("os_ctrl", 2'd0, 32'h8);
        step(3);
        chk("os_hold", {31'd0, bus.IRQ}, 32'd1);
        wr(2'd0, 32'h0);
        chk("os_ack", {31'd0, bus.IRQ}, 32'd0);

        // Auto-reload, PRESET=3: period 6
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        step(2);
        rd_at("ar_load", 2'd2, 32'd3);
        step(3);
        chk("ar_irq1", {31'd0, bus.IRQ}, 32'd1);
        step(1);
        chk("ar_gap", {31'd0, bus.IRQ}, 32'd0);
        step(2);
        rd_at("ar_reload", 2'd2, 32'd3);
        step(3);
        chk("ar_irq2", {31'd0, bus.IRQ}, 32'd1);
        wr(2'd0, 32'h0);

        // Masked one-shot
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        step(6);
        chk("mask_irq", {31'd0, bus.IRQ}, 32'd0);
        wr(2'd0, 32'h8);
        step(2);
        chk("mask_ack", {31'd0, bus.IRQ}, 32'd0);

        // Disable when COUNT reaches 6
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        step(5);
        wr(2'd0, 32'h8);
        step(5);
        rd_at("dis_hold", 2'd2, 32'd6);
        chk("dis_irq", {31'd0, bus.IRQ}, 32'd0);
        wr(2'd0, 32'h9);
        step(2);
        rd_at("dis_reload", 2'd2, 32'd10);
        wr(2'd0, 32'h0);

        // PRESET=0 behaves as 1
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(2);
        chk("p0_pre", {31'd0, bus.IRQ}, 32'd0);
        step(1);
        chk("p0_irq", {31'd0, bus.IRQ}, 32'd1);
        wr(2'd0, 32'h0);

        // PRESET rewritten mid-count
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        step(2);
        wr(2'd1, 32'd7);
        step(3);
        chk("pm_irq", {31'd0, bus.IRQ}, 32'd1);
        step(3);
        rd_at("pm_new", 2'd2, 32'd7);
        wr(2'd0, 32'h0);

        // Write to COUNT ignored; reserved reads 0
        wr(2'd2, 32'd123);
        step(1);
        rd_at("cnt_wr", 2'd2, 32'd6);
        rd_at("rsv_rd", 2'd3, 32'd0);

        // Asynchronous reset mid-count
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        step(5);
        rd_at("ar_pre5", 2'd2, 32'd5);
        rst_n = 1'b0;
        #0.5;
        rd_at("ar_cnt", 2'd2, 32'd0);
        rd_at("ar_pre", 2'd1, 32'd0);
        rd_at("ar_ctrl", 2'd0, 32'd0);
        chk("ar_irq", {31'd0, bus.IRQ}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        rd_at("ar_idle", 2'd2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
